// File: rtl/hdc_sample_sequencer_if.sv
// hdc_sample_sequencer_if: request/accept/done handshake between the sample sequencer and the encoder datapath.
interface hdc_sample_sequencer_if #(parameter int ADDR_W = 16);
  logic              enc_valid;
  logic              enc_ready;
  logic              enc_done;
  logic [ADDR_W-1:0] sample_addr;
  logic              sample_is_train;
  modport master (output enc_valid, sample_addr, sample_is_train, input enc_ready, enc_done);
  modport slave  (input enc_valid, sample_addr, sample_is_train, output enc_ready, enc_done);
endinterface

// File: rtl/hdc_sample_sequencer.sv
// hdc_sample_sequencer: walks the training or testing sample range, one encoder request per sample.
// Optional macro HDC_SEQ_STALL_CNT_EN adds a saturating encoder stall-cycle counter on wait_cycles.
module hdc_sample_sequencer #(
  parameter int NUM_TRAIN = 100,
  parameter int NUM_TEST  = 50,
  parameter int ADDR_W    = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   en,
  input  logic                   training_hdc_model,
  input  logic                   testing_hdc_model,
  hdc_sample_sequencer_if.master enc,
  output logic                   training_dataset_finished,
  output logic                   testing_dataset_finished,
  output logic                   busy,
  output logic [31:0]            wait_cycles
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;
  localparam logic [ADDR_W-1:0] LAST_TRN = ADDR_W'(NUM_TRAIN - 1);
  localparam logic [ADDR_W-1:0] LAST_TST = ADDR_W'(NUM_TEST - 1);
  localparam logic [ADDR_W-1:0] TST_BASE = ADDR_W'(NUM_TRAIN);

  logic [1:0]        r_state, w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_phase, r_trn_fin, r_tst_fin;
  logic              w_start, w_mode, w_abort, w_last;

  assign w_start = en && (training_hdc_model ^ testing_hdc_model);
  assign w_mode  = r_phase ? training_hdc_model : testing_hdc_model;
  assign w_abort = !w_mode || (training_hdc_model && testing_hdc_model);
  assign w_last  = r_cnt == (r_phase ? LAST_TRN : LAST_TST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = w_abort ? S_IDLE : enc.enc_ready ? S_WAIT : S_ISSUE;
      S_WAIT:  w_next = w_abort ? S_IDLE : !enc.enc_done ? S_WAIT : w_last ? S_FIN : S_ISSUE;
      default: w_next = w_mode ? S_FIN : S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_trn_fin <= 1'b0;
      r_tst_fin <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_trn_fin <= r_state == S_WAIT && w_next == S_FIN && r_phase;
      r_tst_fin <= r_state == S_WAIT && w_next == S_FIN && !r_phase;
      if (r_state == S_IDLE && w_start) begin
        r_cnt   <= '0;
        r_phase <= training_hdc_model;
      end else if (r_state == S_WAIT && w_next == S_ISSUE)
        r_cnt <= r_cnt + ADDR_W'(1);
      else if (w_next == S_IDLE)
        r_cnt <= '0;
    end
  end

  assign enc.enc_valid       = r_state == S_ISSUE;
  assign enc.sample_addr     = enc.enc_valid ? (r_phase ? r_cnt : r_cnt + TST_BASE) : '0;
  assign enc.sample_is_train = enc.enc_valid && r_phase;
  assign training_dataset_finished = r_trn_fin;
  assign testing_dataset_finished  = r_tst_fin;
  assign busy = r_state != S_IDLE;

`ifdef HDC_SEQ_STALL_CNT_EN
  logic [31:0] r_wait;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_wait <= '0;
    else if (r_state == S_IDLE && w_start)
      r_wait <= '0;
    else if (((r_state == S_ISSUE && !enc.enc_ready) || r_state == S_WAIT) && r_wait != '1)
      r_wait <= r_wait + 32'd1;
  end
  assign wait_cycles = r_wait;
`else
  assign wait_cycles = '0;
`endif
endmodule

// File: tb/tb_hdc_sample_sequencer.sv
// tb_hdc_sample_sequencer: directed checks of the sequencer with NUM_TRAIN=3, NUM_TEST=2, ADDR_W=8.
module tb_hdc_sample_sequencer;
  logic clk = 0, nrst = 0, en = 0, trn = 0, tst = 0;
  logic trn_fin, tst_fin, busy;
  logic [31:0] wait_cycles;
  int n_pass = 0, n_tot = 0;

  hdc_sample_sequencer_if #(.ADDR_W(8)) bus ();

  hdc_sample_sequencer #(.NUM_TRAIN(3), .NUM_TEST(2), .ADDR_W(8)) dut (
    .clk(clk), .nrst(nrst), .en(en),
    .training_hdc_model(trn), .testing_hdc_model(tst),
    .enc(bus.master),
    .training_dataset_finished(trn_fin), .testing_dataset_finished(tst_fin),
    .busy(busy), .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_wait(input logic [31:0] v);
`ifdef HDC_SEQ_STALL_CNT_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  // Entered with the DUT in S_ISSUE and enc_ready high; done arrives 2 cycles after accept.
  task automatic do_sample(input logic [7:0] addr, input logic is_train, input logic last);
    chk("issue_valid", bus.enc_valid, 1);
    chk("issue_addr", bus.sample_addr, addr);
    chk("issue_train", bus.sample_is_train, is_train);
    tick();
    chk("wait_valid", bus.enc_valid, 0);
    tick();
    bus.enc_done = 1;
    tick();
    bus.enc_done = 0;
    if (last) begin
      chk("fin_trn", trn_fin, is_train);
      chk("fin_tst", tst_fin, !is_train);
    end else begin
      chk("no_fin", trn_fin | tst_fin, 0);
    end
  endtask

  initial begin
    bus.enc_ready = 0;
    bus.enc_done  = 0;
    #12;
    chk("rst_valid", bus.enc_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", bus.sample_addr, 0);
    nrst = 1;
    tick();
    en = 1; trn = 1; tst = 1;
    tick(); tick();
    chk("both_busy", busy, 0);
    chk("both_valid", bus.enc_valid, 0);
    tst = 0; bus.enc_ready = 1;
    tick();
    chk("trn_busy", busy, 1);
    do_sample(8'd0, 1, 0);
    do_sample(8'd1, 1, 0);
    do_sample(8'd2, 1, 1);
    tick();
    chk("trn_pulse_once", trn_fin, 0);
    chk("fin_hold_busy", busy, 1);
    trn = 0;
    tick();
    chk("fin_to_idle", busy, 0);
    tst = 1;
    tick();
    do_sample(8'd3, 0, 0);
    do_sample(8'd4, 0, 1);
    tick();
    chk("tst_pulse_once", tst_fin, 0);
    tst = 0;
    tick();
    chk("tst_idle", busy, 0);
    bus.enc_ready = 0; trn = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", bus.enc_valid, 1);
      chk("stall_addr", bus.sample_addr, 0);
      tick();
    end
    chk("stall_wait5", wait_cycles, exp_wait(5));
    bus.enc_ready = 1;
    tick();
    chk("stall_accepted", bus.enc_valid, 0);
    tick();
    bus.enc_done = 1;
    tick();
    bus.enc_done = 0;
    chk("stall_wait7", wait_cycles, exp_wait(7));
    chk("second_addr", bus.sample_addr, 1);
    tick();
    trn = 0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_nopulse", trn_fin, 0);
    trn = 1;
    tick();
    chk("restart_addr", bus.sample_addr, 0);
    chk("restart_wait0", wait_cycles, 0);
    tick(); tick();
    bus.enc_done = 1;
    tick();
    bus.enc_done = 0;
    tick();
    chk("pre_rst_wait", bus.enc_valid, 0);
    nrst = 0;
    #2;
    chk("arst_busy", busy, 0);
    chk("arst_valid", bus.enc_valid, 0);
    chk("arst_addr", bus.sample_addr, 0);
    chk("arst_train", bus.sample_is_train, 0);
    chk("arst_wait", wait_cycles, 0);
    #1 nrst = 1;
    en = 0; bus.enc_done = 1;
    tick();
    bus.enc_done = 0;
    chk("spur_busy", busy, 0);
    chk("spur_pulse", trn_fin, 0);
    en = 1;
    tick();
    chk("post_rst_addr", bus.sample_addr, 0);
    chk("post_rst_train", bus.sample_is_train, 1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
